// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: next-PC select encodings and default constants.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'b00,
        SEL_BR  = 2'b01,
        SEL_JMP = 2'b10,
        SEL_RET = 2'b11
    } sel_e;

    localparam int unsigned DEF_STEP      = 4;
    localparam int unsigned DEF_RESET_VEC = 0;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with push, pop and same-cycle replace.
// Pushing while full overwrites the oldest entry and sets a sticky overflow flag.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp;
    logic [PW:0]      count;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;
    logic             pop_ok;

    assign top_idx = sp - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;

    // A replace writes over the current top; a plain push writes the next free slot.
    assign wr_idx  = pop_ok ? top_idx : sp;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (en) begin
            if (push && !pop_ok) begin
                sp <= sp + PW'(1);
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + (PW+1)'(1);
                end
            end else if (pop_ok && !push) begin
                sp    <= top_idx;
                count <= count - (PW+1)'(1);
            end
        end
    end

    // NOTE: entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (rst && en && push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: sequential, branch, jump and return next-PC selection.
// Define PC_SEQ_RAS_EN to build the return-address stack; otherwise returns act as sequential.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int unsigned      STEP      = DEF_STEP,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] target,
    input  logic             call,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] old_val,
    output logic             misalign,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf
);

    if (RAS_DEPTH < 2 || !is_pow2(RAS_DEPTH)) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ret_hit;

    assign seq_pc   = out + WIDTH'(STEP);
    assign misalign = |out[1:0];

`ifdef PC_SEQ_RAS_EN
    logic is_ret;

    assign is_ret  = (sel_e'(sel) == SEL_RET);
    assign ret_hit = is_ret && !ras_empty;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall),
        .push      (call),
        .pop       (is_ret),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf)
    );
`else
    logic unused_call;

    assign unused_call = call;
    assign ret_hit     = 1'b0;
    assign ras_top     = '0;
    assign ras_empty   = 1'b1;
    assign ras_full    = 1'b0;
    assign ras_ovf     = 1'b0;
`endif

    // NOTE: next_pc gets a default first so no path through the case can infer a latch.
    always_comb begin
        next_pc = seq_pc;
        case (sel_e'(sel))
            SEL_SEQ: next_pc = seq_pc;
            SEL_BR:  next_pc = out + offset;
            SEL_JMP: next_pc = target;
            SEL_RET: next_pc = ret_hit ? ras_top : seq_pc;
            default: next_pc = seq_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out     <= RESET_VEC;
            old_val <= RESET_VEC;
        end else if (!stall) begin
            old_val <= out;
            out     <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed, table-driven bench for pc_seq_unit; follows the stack path when PC_SEQ_RAS_EN is defined.
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] offset;
    logic [31:0] target;
    logic        call;
    logic [31:0] out;
    logic [31:0] old_val;
    logic        misalign;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  sel;
        logic [31:0] offset;
        logic [31:0] target;
        logic        call;
        logic [31:0] exp_out;
        logic [31:0] exp_old;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[$];

    pc_seq_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .sel       (sel),
        .offset    (offset),
        .target    (target),
        .call      (call),
        .out       (out),
        .old_val   (old_val),
        .misalign  (misalign),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic [1:0] sl,
                                input logic [31:0] off, input logic [31:0] tgt, input logic c,
                                input logic [31:0] eo, input logic [31:0] eold,
                                input logic emp, input logic ful, input logic ov);
        vec_t v;
        v.rst = r;        v.stall = s;      v.sel = sl;
        v.offset = off;   v.target = tgt;   v.call = c;
        v.exp_out = eo;   v.exp_old = eold;
        v.exp_empty = emp; v.exp_full = ful; v.exp_ovf = ov;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        rst    = v.rst;
        stall  = v.stall;
        sel    = v.sel;
        offset = v.offset;
        target = v.target;
        call   = v.call;
        @(posedge clk);
        #1;
        check({tag, ".out"},       out,              v.exp_out);
        check({tag, ".old_val"},   old_val,          v.exp_old);
        check({tag, ".misalign"},  {31'd0, misalign}, {31'd0, |v.exp_out[1:0]});
        check({tag, ".ras_empty"}, {31'd0, ras_empty}, {31'd0, v.exp_empty});
        check({tag, ".ras_full"},  {31'd0, ras_full},  {31'd0, v.exp_full});
        check({tag, ".ras_ovf"},   {31'd0, ras_ovf},   {31'd0, v.exp_ovf});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; sel = 2'b00; offset = '0; target = '0; call = 1'b0;
        #2;

        // Reset, sequential stepping, branch, misaligned jump, wrap, empty return.
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        0, 32'h0000_0000, 32'h0000_0000, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,        0, 32'h0000_0004, 32'h0000_0000, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,        0, 32'h0000_0008, 32'h0000_0004, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,        0, 32'h0000_000C, 32'h0000_0008, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'b10, 32'h0,        32'h100,      0, 32'h0000_0100, 32'h0000_000C, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'b01, 32'hFFFF_FFF0, 32'h0,       0, 32'h0000_00F0, 32'h0000_0100, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'b10, 32'h0,        32'h102,      0, 32'h0000_0102, 32'h0000_00F0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'b10, 32'h0,        32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0000_0102, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,        0, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'b11, 32'h0,        32'h0,        0, 32'h0000_0004, 32'h0000_0000, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'b10, 32'h0,        32'h40,       0, 32'h0000_0040, 32'h0000_0004, 1, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef PC_SEQ_RAS_EN
        // Call then return.
        apply(mk(1, 0, 2'b10, 0, 32'h200, 1, 32'h0000_0200, 32'h0000_0040, 0, 0, 0), "call_200");
        apply(mk(1, 0, 2'b11, 0, 32'h0,   0, 32'h0000_0044, 32'h0000_0200, 1, 0, 0), "ret_44");

        // Five calls into a four-deep stack: oldest entry (0x48) is lost.
        apply(mk(1, 0, 2'b10, 0, 32'h1000, 1, 32'h0000_1000, 32'h0000_0044, 0, 0, 0), "c1");
        apply(mk(1, 0, 2'b10, 0, 32'h2000, 1, 32'h0000_2000, 32'h0000_1000, 0, 0, 0), "c2");
        apply(mk(1, 0, 2'b10, 0, 32'h3000, 1, 32'h0000_3000, 32'h0000_2000, 0, 0, 0), "c3");
        apply(mk(1, 0, 2'b10, 0, 32'h4000, 1, 32'h0000_4000, 32'h0000_3000, 0, 1, 0), "c4");
        apply(mk(1, 0, 2'b10, 0, 32'h5000, 1, 32'h0000_5000, 32'h0000_4000, 0, 1, 1), "c5");
        apply(mk(1, 0, 2'b11, 0, 32'h0, 0, 32'h0000_4004, 32'h0000_5000, 0, 0, 1), "r1");
        apply(mk(1, 0, 2'b11, 0, 32'h0, 0, 32'h0000_3004, 32'h0000_4004, 0, 0, 1), "r2");
        apply(mk(1, 0, 2'b11, 0, 32'h0, 0, 32'h0000_2004, 32'h0000_3004, 0, 0, 1), "r3");
        apply(mk(1, 0, 2'b11, 0, 32'h0, 0, 32'h0000_1004, 32'h0000_2004, 1, 0, 1), "r4");
        apply(mk(1, 0, 2'b11, 0, 32'h0, 0, 32'h0000_1008, 32'h0000_1004, 1, 0, 1), "r5_empty");

        // Same-cycle pop and push replaces the top; call with return on empty stack only pushes.
        apply(mk(1, 0, 2'b10, 0, 32'h300, 1, 32'h0000_0300, 32'h0000_1008, 0, 0, 1), "rep_call");
        apply(mk(1, 0, 2'b11, 0, 32'h0,   1, 32'h0000_100C, 32'h0000_0300, 0, 0, 1), "rep_swap");
        apply(mk(1, 0, 2'b11, 0, 32'h0,   0, 32'h0000_0304, 32'h0000_100C, 1, 0, 1), "rep_pop");
        apply(mk(1, 0, 2'b11, 0, 32'h0,   1, 32'h0000_0308, 32'h0000_0304, 0, 0, 1), "empty_call");
        apply(mk(1, 0, 2'b11, 0, 32'h0,   0, 32'h0000_0308, 32'h0000_0308, 1, 0, 1), "empty_call_pop");

        // Stall holds PC, history and stack; then reset wins over stall.
        apply(mk(1, 0, 2'b10, 0, 32'h8000, 1, 32'h0000_8000, 32'h0000_0308, 0, 0, 1), "pre_stall");
        for (int k = 0; k < 3; k++)
            apply(mk(1, 1, 2'b10, 0, 32'h9000, 1, 32'h0000_8000, 32'h0000_0308, 0, 0, 1), $sformatf("stall%0d", k));
        apply(mk(1, 0, 2'b11, 0, 32'h0, 0, 32'h0000_030C, 32'h0000_8000, 1, 0, 1), "post_stall_ret");
        apply(mk(1, 0, 2'b10, 0, 32'h500, 1, 32'h0000_0500, 32'h0000_030C, 0, 0, 1), "pre_rst");
        apply(mk(0, 1, 2'b10, 0, 32'h9000, 1, 32'h0000_0000, 32'h0000_0000, 1, 0, 0), "rst_in_stall");
        apply(mk(1, 0, 2'b00, 0, 32'h0, 0, 32'h0000_0004, 32'h0000_0000, 1, 0, 0), "after_rst");
`else
        // No stack: return behaves as sequential, call has no effect.
        apply(mk(1, 0, 2'b10, 0, 32'h10,  0, 32'h0000_0010, 32'h0000_0040, 1, 0, 0), "jmp_10");
        apply(mk(1, 0, 2'b11, 0, 32'h0,   1, 32'h0000_0014, 32'h0000_0010, 1, 0, 0), "ret_call_noras");
        apply(mk(1, 0, 2'b10, 0, 32'h200, 1, 32'h0000_0200, 32'h0000_0014, 1, 0, 0), "call_noras");
        for (int k = 0; k < 3; k++)
            apply(mk(1, 1, 2'b10, 0, 32'h9000, 1, 32'h0000_0200, 32'h0000_0014, 1, 0, 0), $sformatf("stall%0d", k));
        apply(mk(0, 1, 2'b10, 0, 32'h9000, 1, 32'h0000_0000, 32'h0000_0000, 1, 0, 0), "rst_in_stall");
        apply(mk(1, 0, 2'b00, 0, 32'h0, 0, 32'h0000_0004, 32'h0000_0000, 1, 0, 0), "after_rst");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
